// File: rtl/layer_priority_mux_pkg.sv
// Shared constants and helpers for the layered object multiplexer.
// Imported by the mux top and its blink counter.
package layer_mux_pkg;

    localparam logic [7:0] TRANSPARENT_DEF = 8'hFF;
    localparam int         MAX_LAYERS      = 16;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_priority_mux_blink_frame_counter.sv
// Frame counter producing the blink phase for blinking layers.
// The phase toggles every BLINK_FRAMES startOfFrame pulses.
module blink_frame_counter
    import layer_mux_pkg::*;
#(
    parameter int BLINK_FRAMES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    output logic blink_phase
);

    logic [7:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (startOfFrame) begin
            if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/layer_priority_mux.sv
// Two-stage priority mux over object layers with enable, transparency,
// blinking and per-frame overlap flags. Layer 0 has top priority.
module layer_priority_mux
    import layer_mux_pkg::*;
#(
    parameter int                NUM_LAYERS   = 8,
    parameter int                RGB_W        = 8,
    parameter logic [RGB_W-1:0]  TRANSPARENT  = RGB_W'(TRANSPARENT_DEF),
    parameter int                BLINK_FRAMES = 15,
    localparam int               IDX_W        = idx_w(NUM_LAYERS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              startOfFrame,
    input  logic [NUM_LAYERS-1:0]             dr,
    input  logic [NUM_LAYERS-1:0][RGB_W-1:0]  rgb,
    input  logic [NUM_LAYERS-1:0]             layer_en,
    input  logic [NUM_LAYERS-1:0]             blink_en,
    output logic                              drawingRequest,
    output logic [RGB_W-1:0]                  RGBout,
    output logic [IDX_W-1:0]                  layer_idx,
    output logic [NUM_LAYERS-1:0]             overlap
);

    logic                             blink_phase;
    logic [NUM_LAYERS-1:0]            vis_d;
    logic [NUM_LAYERS-1:0]            vis_q;
    logic [NUM_LAYERS-1:0][RGB_W-1:0] rgb_q;
    logic                             sel_hit;
    logic [IDX_W-1:0]                 sel_idx;
    logic [RGB_W-1:0]                 sel_rgb;
    logic                             multi;
    logic [NUM_LAYERS-1:0]            contrib;
    logic [NUM_LAYERS-1:0]            acc;

    blink_frame_counter #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .blink_phase  (blink_phase)
    );

    always_comb begin
        vis_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            vis_d[i] = dr[i] & layer_en[i]
                     & (rgb[i] != TRANSPARENT)
                     & ~(blink_en[i] & ~blink_phase);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vis_q <= '0;
            rgb_q <= {NUM_LAYERS{TRANSPARENT}};
        end else begin
            vis_q <= vis_d;
            rgb_q <= rgb;
        end
    end

    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_rgb = TRANSPARENT;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (vis_q[i]) begin
                sel_hit = 1'b1;
                sel_idx = IDX_W'(i);
                sel_rgb = rgb_q[i];
                break;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drawingRequest <= 1'b0;
            RGBout         <= TRANSPARENT;
            layer_idx      <= '0;
        end else begin
            drawingRequest <= sel_hit;
            RGBout         <= sel_rgb;
            layer_idx      <= sel_idx;
        end
    end

    // Stage-1 pixel present at startOfFrame still belongs to the closing frame.
    assign multi   = $countones(vis_q) > 1;
    assign contrib = multi ? vis_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            overlap <= '0;
        end else if (startOfFrame) begin
            overlap <= acc | contrib;
            acc     <= '0;
        end else begin
            acc <= acc | contrib;
        end
    end

endmodule
